// File: rtl/npower_ledsw_port.sv
// LED/switch peripheral: LED register, debounced switches with change latch, level IRQ.
// Latency: ack/dato one cycle after req; switch to irq DBNC_CYCLES+3 edges.
// Backpressure: none; the master must drop req for one cycle between transfers.
module npower_ledsw_port #(
   parameter logic [15:0] DBNC_CYCLES = 16'd50000,
   parameter logic [7:0]  LED_RST     = 8'h00
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cs,
   input  logic        cyc,
   input  logic        stb,
   input  logic        we,
   input  logic [3:0]  sel,
   input  logic [3:0]  adr,
   input  logic [31:0] dati,
   output logic [31:0] dato,
   output logic        ack,
   input  logic [7:0]  sw,
   output logic [7:0]  led,
   output logic        irq
);

   localparam logic [15:0] CNT_MAX = DBNC_CYCLES - 16'd1;

   // register state
   logic [7:0]  led_q, led_d;
   logic [7:0]  deb_q, deb_d;
   logic [7:0]  chg_q, chg_d;
   logic [7:0]  ien_q, ien_d;
   logic        ack_q, ack_d;
   logic [31:0] dato_q, dato_d;
   logic        irq_q, irq_d;
   logic [7:0]  s1_q;
   logic [7:0]  s2_q;
   logic [15:0] cnt_q [8];
   logic [15:0] cnt_d [8];

   // bus decode
   logic        req;
   logic        wr_en;
   logic        wr_led;
   logic        wr_chg;
   logic        wr_ien;
   logic [7:0]  rdata;
   logic [7:0]  chg_set;

   // upper data bits, unused byte lanes and the byte offset carry no function here
   logic unused_bits;
   assign unused_bits = ^{sel[3:1], adr[1:0], dati[31:8]};

   // request qualification and single-commit write strobes (commit only before ack rises)
   always_comb begin
      req    = cs & cyc & stb;
      wr_en  = req & we & ~ack_q & sel[0];
      wr_led = wr_en & (adr[3:2] == 2'd0);
      wr_chg = wr_en & (adr[3:2] == 2'd2);
      wr_ien = wr_en & (adr[3:2] == 2'd3);
      case (adr[3:2])
         2'd0:    rdata = led_q;
         2'd1:    rdata = deb_q;
         2'd2:    rdata = chg_q;
         default: rdata = ien_q;
      endcase
   end

   // per-switch debounce: accept a new level after DBNC_CYCLES stable cycles
   always_comb begin
      deb_d   = deb_q;
      chg_set = 8'h00;
      for (int i = 0; i < 8; i++) begin
         cnt_d[i] = 16'd0;
         if (s2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_MAX) begin
               deb_d[i]   = s2_q[i];
               chg_set[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + 16'd1;
            end
         end
      end
   end

   // register next-state: W1C on chg loses to a concurrent change-set
   always_comb begin
      led_d  = wr_led ? dati[7:0] : led_q;
      ien_d  = wr_ien ? dati[7:0] : ien_q;
      chg_d  = (chg_q & ~(wr_chg ? dati[7:0] : 8'h00)) | chg_set;
      irq_d  = |(chg_q & ien_q);
      ack_d  = req;
      dato_d = req ? {24'h0, rdata} : 32'h0;
   end

   // state update with synchronous reset; a transfer under reset is dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         led_q  <= LED_RST;
         deb_q  <= 8'h00;
         chg_q  <= 8'h00;
         ien_q  <= 8'h00;
         ack_q  <= 1'b0;
         dato_q <= 32'h0;
         irq_q  <= 1'b0;
         s1_q   <= 8'h00;
         s2_q   <= 8'h00;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= 16'd0;
         end
      end else begin
         led_q  <= led_d;
         deb_q  <= deb_d;
         chg_q  <= chg_d;
         ien_q  <= ien_d;
         ack_q  <= ack_d;
         dato_q <= dato_d;
         irq_q  <= irq_d;
         s1_q   <= sw;
         s2_q   <= s1_q;
         for (int i = 0; i < 8; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign led  = led_q;
   assign ack  = ack_q;
   assign dato = dato_q;
   assign irq  = irq_q;

endmodule

// File: tb/tb_npower_ledsw_port.sv
// Bench for npower_ledsw_port with a short debounce window.
// Latency: register path checked at the ack cycle; switch path counted edge by edge.
// Backpressure: not applicable; transfers are spaced with one idle cycle.
module tb_npower_ledsw_port;

   logic        clk = 1'b0;
   logic        rst;
   logic        cs, cyc, stb, we;
   logic [3:0]  sel, adr;
   logic [31:0] dati;
   logic [31:0] dato;
   logic        ack;
   logic [7:0]  sw;
   logic [7:0]  led;
   logic        irq;

   int checks   = 0;
   int failures = 0;

   npower_ledsw_port #(.DBNC_CYCLES(16'd4), .LED_RST(8'h00)) dut (
      .clk(clk), .rst(rst), .cs(cs), .cyc(cyc), .stb(stb), .we(we),
      .sel(sel), .adr(adr), .dati(dati), .dato(dato), .ack(ack),
      .sw(sw), .led(led), .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        w;
      logic [3:0]  s;
      logic [3:0]  a;
      logic [31:0] d;
      logic [31:0] exp_dato;
      logic [7:0]  exp_led;
   } vec_t;

   vec_t vecs [14];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic req_on(input logic w, input logic [3:0] s, input logic [3:0] a, input logic [31:0] d);
      cs = 1'b1; cyc = 1'b1; stb = 1'b1;
      we = w; sel = s; adr = a; dati = d;
   endtask

   task automatic req_off();
      cs = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
      sel = 4'h0; dati = 32'h0;
   endtask

   // one full transfer: request edge, then idle edge; returns values seen while ack is high
   task automatic xfer(input logic w, input logic [3:0] s, input logic [3:0] a, input logic [31:0] d,
                       output logic [31:0] rd, output logic ak, output logic [7:0] lk);
      req_on(w, s, a, d);
      tick();
      ak = ack; rd = dato; lk = led;
      req_off();
      tick();
      chk("ack_drop", {31'h0, ack}, 32'h0);
      chk("dato_idle", dato, 32'h0);
   endtask

   logic [31:0] rd;
   logic        ak;
   logic [7:0]  lk;

   initial begin
      // stimulus table: writes check led at ack, reads check dato at ack
      vecs[0]  = '{1'b0, 4'h1, 4'h0, 32'h0,        32'h0,        8'h00};
      vecs[1]  = '{1'b0, 4'h1, 4'h4, 32'h0,        32'h0,        8'h00};
      vecs[2]  = '{1'b0, 4'h1, 4'h8, 32'h0,        32'h0,        8'h00};
      vecs[3]  = '{1'b0, 4'h1, 4'hC, 32'h0,        32'h0,        8'h00};
      vecs[4]  = '{1'b1, 4'h1, 4'h0, 32'h000000A5, 32'h0,        8'hA5};
      vecs[5]  = '{1'b0, 4'h1, 4'h0, 32'h0,        32'h000000A5, 8'hA5};
      vecs[6]  = '{1'b1, 4'h2, 4'h0, 32'h000000FF, 32'h0,        8'hA5};
      vecs[7]  = '{1'b0, 4'h1, 4'h1, 32'h0,        32'h000000A5, 8'hA5};
      vecs[8]  = '{1'b1, 4'h1, 4'h4, 32'h000000FF, 32'h0,        8'hA5};
      vecs[9]  = '{1'b0, 4'h1, 4'h4, 32'h0,        32'h0,        8'hA5};
      vecs[10] = '{1'b1, 4'h1, 4'hC, 32'hFFFFFF5A, 32'h0,        8'hA5};
      vecs[11] = '{1'b0, 4'h1, 4'hC, 32'h0,        32'h0000005A, 8'hA5};
      vecs[12] = '{1'b1, 4'h1, 4'hC, 32'h0,        32'h0,        8'hA5};
      vecs[13] = '{1'b0, 4'h1, 4'hC, 32'h0,        32'h0,        8'hA5};

      // reset
      rst = 1'b1; sw = 8'h00; adr = 4'h0;
      req_off();
      tick(); tick();
      rst = 1'b0;
      chk("rst_led", {24'h0, led}, 32'h0);
      chk("rst_irq", {31'h0, irq}, 32'h0);
      chk("rst_ack", {31'h0, ack}, 32'h0);
      chk("rst_dato", dato, 32'h0);

      // reset during a transfer drops it
      req_on(1'b1, 4'h1, 4'h0, 32'h00000055);
      rst = 1'b1;
      tick();
      chk("rst_xfer_ack", {31'h0, ack}, 32'h0);
      chk("rst_xfer_led", {24'h0, led}, 32'h0);
      rst = 1'b0;
      req_off();
      tick();
      chk("rst_xfer_ack2", {31'h0, ack}, 32'h0);

      // register table
      for (int i = 0; i < 14; i++) begin
         xfer(vecs[i].w, vecs[i].s, vecs[i].a, vecs[i].d, rd, ak, lk);
         chk($sformatf("vec%0d_ack", i), {31'h0, ak}, 32'h1);
         chk($sformatf("vec%0d_led", i), {24'h0, lk}, {24'h0, vecs[i].exp_led});
         if (!vecs[i].w) chk($sformatf("vec%0d_dato", i), rd, vecs[i].exp_dato);
      end

      // glitch of 3 cycles is rejected
      sw = 8'h08;
      repeat (3) tick();
      sw = 8'h00;
      repeat (10) tick();
      chk("glitch_deb", {24'h0, dut.deb_q}, 32'h0);
      chk("glitch_chg", {24'h0, dut.chg_q}, 32'h0);

      // held switch accepted exactly 6 edges later
      sw = 8'h08;
      repeat (5) tick();
      chk("deb_early", {24'h0, dut.deb_q}, 32'h0);
      tick();
      chk("deb_set", {24'h0, dut.deb_q}, 32'h08);
      chk("chg_set", {24'h0, dut.chg_q}, 32'h08);
      xfer(1'b0, 4'h1, 4'h4, 32'h0, rd, ak, lk);
      chk("swstat_rd", rd, 32'h08);
      xfer(1'b0, 4'h1, 4'h8, 32'h0, rd, ak, lk);
      chk("swchg_rd", rd, 32'h08);

      // interrupt path
      xfer(1'b1, 4'h1, 4'h8, 32'h08, rd, ak, lk);
      xfer(1'b1, 4'h1, 4'hC, 32'h08, rd, ak, lk);
      chk("irq_idle", {31'h0, irq}, 32'h0);
      sw = 8'h00;
      repeat (6) tick();
      chk("irq_chg_set", {24'h0, dut.chg_q}, 32'h08);
      chk("irq_not_yet", {31'h0, irq}, 32'h0);
      tick();
      chk("irq_rise", {31'h0, irq}, 32'h1);
      xfer(1'b1, 4'h1, 4'h8, 32'h00, rd, ak, lk);
      chk("w1c_zero_chg", {24'h0, dut.chg_q}, 32'h08);
      chk("w1c_zero_irq", {31'h0, irq}, 32'h1);
      req_on(1'b1, 4'h1, 4'hC, 32'h00);
      tick();
      chk("ien_off_commit", {31'h0, irq}, 32'h1);
      req_off();
      tick();
      chk("ien_off_after", {31'h0, irq}, 32'h0);
      req_on(1'b1, 4'h1, 4'hC, 32'h08);
      tick();
      chk("ien_on_commit", {31'h0, irq}, 32'h0);
      req_off();
      tick();
      chk("ien_on_after", {31'h0, irq}, 32'h1);
      req_on(1'b1, 4'h1, 4'h8, 32'h08);
      tick();
      chk("w1c_commit_irq", {31'h0, irq}, 32'h1);
      req_off();
      tick();
      chk("w1c_after_irq", {31'h0, irq}, 32'h0);
      chk("w1c_after_chg", {24'h0, dut.chg_q}, 32'h0);

      // set beats clear on the same edge
      sw = 8'h08;
      repeat (5) tick();
      req_on(1'b1, 4'h1, 4'h8, 32'h08);
      tick();
      chk("race_deb", {24'h0, dut.deb_q}, 32'h08);
      chk("race_chg", {24'h0, dut.chg_q}, 32'h08);
      req_off();
      tick();
      chk("race_irq", {31'h0, irq}, 32'h1);
      xfer(1'b0, 4'h1, 4'h8, 32'h0, rd, ak, lk);
      chk("race_rd", rd, 32'h08);

      // multiple switches
      sw = 8'h00;
      repeat (8) tick();
      xfer(1'b1, 4'h1, 4'h8, 32'hFF, rd, ak, lk);
      xfer(1'b1, 4'h1, 4'hC, 32'h01, rd, ak, lk);
      tick();
      chk("multi_irq0", {31'h0, irq}, 32'h0);
      sw = 8'h81;
      repeat (5) tick();
      chk("multi_deb_early", {24'h0, dut.deb_q}, 32'h0);
      tick();
      chk("multi_deb", {24'h0, dut.deb_q}, 32'h81);
      chk("multi_chg", {24'h0, dut.chg_q}, 32'h81);
      tick();
      chk("multi_irq1", {31'h0, irq}, 32'h1);
      xfer(1'b1, 4'h1, 4'h8, 32'h01, rd, ak, lk);
      chk("multi_irq_clr", {31'h0, irq}, 32'h0);
      xfer(1'b0, 4'h1, 4'h8, 32'h0, rd, ak, lk);
      chk("multi_chg_rd", rd, 32'h80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
